// File: rtl/fft_pkg.sv
// Shared types and butterfly address arithmetic for the in-place radix-2 DIT FFT sequencer.
package fft_pkg;

    localparam int MAX_LOG2_N = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } t_fft_seq_state;

    typedef struct packed {
        logic [MAX_LOG2_N-1:0] addr_a;
        logic [MAX_LOG2_N-1:0] addr_b;
        logic [MAX_LOG2_N-2:0] tw;
    } t_bfly_addr;

    // Operand pair and twiddle index for butterfly b of stage s, sized for the largest transform.
    function automatic t_bfly_addr bfly_addr(input int unsigned log2n, input int unsigned s,
                                             input int unsigned b);
        t_bfly_addr r;
        r.addr_a = MAX_LOG2_N'(((b >> s) << (s + 1)) | (b & ((1 << s) - 1)));
        r.addr_b = r.addr_a | MAX_LOG2_N'(1 << s);
        r.tw     = (MAX_LOG2_N-1)'((b & ((1 << s) - 1)) << (log2n - 1 - s));
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Enable-gated shift register that replays read strobes/addresses as write strobes/addresses.
module fft_addr_delay
    import fft_pkg::*;
#(
    parameter int W     = 7,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] line_p [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                line_p[i] <= '0;
            end
        end else if (i_en) begin
            line_p[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                line_p[i] <= line_p[i-1];
            end
        end
    end

    assign o_q = line_p[DEPTH-1];

endmodule

// File: rtl/fft_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 DIT FFT with latency-matched write-back.
// Optional build macro FFT_SEQ_ABORT_EN adds i_abort to cancel a transform in progress.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2_N   = 3,
    parameter int BFLY_LAT = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic                       i_start,
`ifdef FFT_SEQ_ABORT_EN
    input  logic                       i_abort,
`endif
    output logic                       o_active,
    output logic                       o_done,
    output logic [$clog2(LOG2_N)-1:0]  o_stage,
    output logic                       o_rd_en,
    output logic [LOG2_N-1:0]          o_rd_addr_a,
    output logic [LOG2_N-1:0]          o_rd_addr_b,
    output logic [LOG2_N-2:0]          o_tw_addr,
    output logic                       o_wr_en,
    output logic [LOG2_N-1:0]          o_wr_addr_a,
    output logic [LOG2_N-1:0]          o_wr_addr_b
);

    localparam int SW = $clog2(LOG2_N);
    localparam int CW = $clog2(BFLY_LAT + 1);
    localparam int DW = 1 + 2 * LOG2_N;
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2_N - 1);

    t_fft_seq_state    state;
    logic [SW-1:0]     stage;
    logic [LOG2_N-2:0] bfly;
    logic [CW-1:0]     drain_cnt;
    logic              abort_req;
    logic              rd_en;
    t_bfly_addr        bfly_full;
    logic              unused_bfly_bits;
    logic [DW-1:0]     wr_bus;

`ifdef FFT_SEQ_ABORT_EN
    assign abort_req = i_abort && (state == RUN || state == DRAIN);
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            stage     <= '0;
            bfly      <= '0;
            drain_cnt <= '0;
        end else if (i_en) begin
            if (abort_req) begin
                state     <= IDLE;
                stage     <= '0;
                bfly      <= '0;
                drain_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            state <= RUN;
                            stage <= '0;
                            bfly  <= '0;
                        end
                    end
                    RUN: begin
                        bfly <= bfly + 1'b1;
                        if (bfly == '1) begin
                            state     <= DRAIN;
                            drain_cnt <= CW'(BFLY_LAT);
                        end
                    end
                    DRAIN: begin
                        // Hold off the next stage until the last write-back of this one has landed.
                        if (drain_cnt == CW'(1)) begin
                            drain_cnt <= '0;
                            if (stage == LAST_STAGE) begin
                                state <= DONE;
                            end else begin
                                stage <= stage + 1'b1;
                                state <= RUN;
                            end
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        stage <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_comb bfly_full = bfly_addr(LOG2_N, 32'(stage), 32'(bfly));
    assign unused_bfly_bits = ^bfly_full;

    assign rd_en       = (state == RUN);
    assign o_rd_en     = rd_en;
    assign o_rd_addr_a = rd_en ? bfly_full.addr_a[LOG2_N-1:0] : '0;
    assign o_rd_addr_b = rd_en ? bfly_full.addr_b[LOG2_N-1:0] : '0;
    assign o_tw_addr   = rd_en ? bfly_full.tw[LOG2_N-2:0] : '0;
    assign o_active    = (state == RUN) || (state == DRAIN);
    assign o_done      = (state == DONE);
    assign o_stage     = stage;

    fft_addr_delay #(
        .W    (DW),
        .DEPTH(BFLY_LAT)
    ) u_wr_delay (
        .i_clk(i_clk),
        .i_clr(i_rst || (i_en && abort_req)),
        .i_en (i_en),
        .i_d  ({o_rd_en, o_rd_addr_a, o_rd_addr_b}),
        .o_q  (wr_bus)
    );

    assign {o_wr_en, o_wr_addr_a, o_wr_addr_b} = wr_bus;

endmodule

// File: tb/tb_fft_sequencer.sv
// Randomised self-checking bench for fft_sequencer against a transform-timeline reference model.
module tb_fft_sequencer;
    import fft_pkg::*;

    localparam int LOG2_N   = 3;
    localparam int BFLY_LAT = 2;
    localparam int N        = 1 << LOG2_N;
    localparam int H        = N / 2;
    localparam int P        = H + BFLY_LAT;
    localparam int T        = LOG2_N * P;
    localparam int SW       = $clog2(LOG2_N);
`ifdef FFT_SEQ_ABORT_EN
    localparam bit HAS_ABORT = 1'b1;
`else
    localparam bit HAS_ABORT = 1'b0;
`endif

    logic                i_clk;
    logic                i_rst;
    logic                i_en;
    logic                i_start;
    logic                i_abort;
    logic                o_active;
    logic                o_done;
    logic [SW-1:0]       o_stage;
    logic                o_rd_en;
    logic [LOG2_N-1:0]   o_rd_addr_a;
    logic [LOG2_N-1:0]   o_rd_addr_b;
    logic [LOG2_N-2:0]   o_tw_addr;
    logic                o_wr_en;
    logic [LOG2_N-1:0]   o_wr_addr_a;
    logic [LOG2_N-1:0]   o_wr_addr_b;

    typedef struct packed {
        logic              en;
        logic [LOG2_N-1:0] a;
        logic [LOG2_N-1:0] b;
        logic [LOG2_N-2:0] tw;
    } rd_t;

    int n_chk = 0;
    int n_err = 0;
    int k = -1;          // -1 idle, 0..T-1 active cycle index, T done cycle
    int act_cnt = 0;
    int done_cnt = 0;

    fft_sequencer #(
        .LOG2_N  (LOG2_N),
        .BFLY_LAT(BFLY_LAT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_start    (i_start),
`ifdef FFT_SEQ_ABORT_EN
        .i_abort    (i_abort),
`endif
        .o_active   (o_active),
        .o_done     (o_done),
        .o_stage    (o_stage),
        .o_rd_en    (o_rd_en),
        .o_rd_addr_a(o_rd_addr_a),
        .o_rd_addr_b(o_rd_addr_b),
        .o_tw_addr  (o_tw_addr),
        .o_wr_en    (o_wr_en),
        .o_wr_addr_a(o_wr_addr_a),
        .o_wr_addr_b(o_wr_addr_b)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Butterfly read issued at active cycle kk: groups of 2^s pairs, stride 2^(s+1).
    function automatic rd_t ref_read(input int kk);
        rd_t r;
        int st, bb, blk, g, j, a;
        r = '0;
        if (kk < 0 || kk >= T) return r;
        st = kk / P;
        bb = kk % P;
        if (bb >= H) return r;
        blk  = 1 << st;
        g    = bb / blk;
        j    = bb % blk;
        a    = g * 2 * blk + j;
        r.en = 1'b1;
        r.a  = LOG2_N'(a);
        r.b  = LOG2_N'(a + blk);
        r.tw = (LOG2_N-1)'(j * (H / blk));
        return r;
    endfunction

    function automatic logic [63:0] ref_outputs(input int kk);
        rd_t r, w;
        logic act, dn;
        logic [SW-1:0] st;
        r   = ref_read(kk);
        w   = ref_read(kk - BFLY_LAT);
        act = (kk >= 0 && kk < T);
        dn  = (kk == T);
        if (kk < 0) st = '0;
        else if (kk >= T) st = SW'(LOG2_N - 1);
        else st = SW'(kk / P);
        return 64'({act, dn, st, r, w.en, w.a, w.b});
    endfunction

    task automatic step(input logic en, input logic st, input logic rs, input logic ab);
        logic [63:0] obs;
        i_en    = en;
        i_start = st;
        i_rst   = rs;
        i_abort = ab;
        @(posedge i_clk);
        if (rs) k = -1;
        else if (en) begin
            if (k == -1) begin
                if (st) k = 0;
            end else if (HAS_ABORT && ab && k < T) k = -1;
            else if (k == T) k = -1;
            else k++;
        end
        #1;
        obs = 64'({o_active, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
                   o_wr_en, o_wr_addr_a, o_wr_addr_b});
        chk($sformatf("cycle k=%0d", k), obs, ref_outputs(k));
        if (o_active) act_cnt++;
        if (o_done) done_cnt++;
    endtask

    task automatic run_xfer(input string name, input int freeze_k, input int rst_k,
                            input int abort_k, input bit noisy, input int exp_act,
                            input int exp_done);
        int   fl;
        logic en, st, rs, ab;
        fl       = 3;
        act_cnt  = 0;
        done_cnt = 0;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < T + 20 && k != -1; c++) begin
            en = 1'b1;
            rs = (k == rst_k);
            ab = (k == abort_k);
            st = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k == freeze_k && fl > 0) begin
                en = 1'b0;
                fl--;
            end
            step(en, st, rs, ab);
        end
        chk({name, " active cycles"}, 64'(act_cnt), 64'(exp_act));
        chk({name, " done pulses"}, 64'(done_cnt), 64'(exp_done));
    endtask

    initial begin
        t_bfly_addr fa;
        rd_t        ra;
        i_rst   = 1'b1;
        i_en    = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;

        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        act_cnt = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle active cycles", 64'(act_cnt), 64'd0);

        for (int s = 0; s < LOG2_N; s++) begin
            for (int b = 0; b < H; b++) begin
                fa = bfly_addr(LOG2_N, s, b);
                ra = ref_read(s * P + b);
                chk($sformatf("pkg bfly_addr s=%0d b=%0d", s, b),
                    64'({fa.addr_a[LOG2_N-1:0], fa.addr_b[LOG2_N-1:0], fa.tw[LOG2_N-2:0]}),
                    64'({ra.a, ra.b, ra.tw}));
            end
        end

        run_xfer("full", -2, -2, -2, 1'b0, T, 1);
        run_xfer("start held", -2, -2, -2, 1'b1, T, 1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        run_xfer("freeze", P + 2, -2, -2, 1'b0, T + 3, 1);
        run_xfer("reset in drain", -2, P + H, -2, 1'b0, P + H + 1, 0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        run_xfer("after reset", -2, -2, -2, 1'b0, T, 1);
`ifdef FFT_SEQ_ABORT_EN
        run_xfer("abort", -2, -2, 2 * P + 1, 1'b0, 2 * P + 2, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 29) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
Control and address sequencer inside the FFT engine; it is the responder to the spectrum analyser controller's start/active handshake. On a start pulse it steps an in-place radix-2 DIT FFT through LOG2_N stages of N/2 butterflies each. Per butterfly it issues the read addresses for the operand pair and the twiddle ROM address. It generates the write-back addresses delayed to match the butterfly datapath latency. o_active stays high for the whole transform, and o_done pulses at the end.

Parameters:
LOG2_N, 3, log2 of transform length; N = 2^LOG2_N; legal range 2..12.
BFLY_LAT, 2, cycles from butterfly operand read request to result write; legal range 1..8.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_en  in  1  global clock enable; when low, all state, counters and delay lines hold
i_start  in  1  start request; honoured only in IDLE with i_en=1
o_active  out  1  high while a transform is in progress (RUN, DRAIN)
o_done  out  1  one-cycle pulse in DONE
o_stage  out  $clog2(LOG2_N)  current stage index s
o_rd_en  out  1  operand read strobe
o_rd_addr_a  out  LOG2_N  upper-wing read address
o_rd_addr_b  out  LOG2_N  lower-wing read address
o_tw_addr  out  LOG2_N-1  twiddle ROM index
o_wr_en  out  1  result write strobe
o_wr_addr_a  out  LOG2_N  upper-wing write address
o_wr_addr_b  out  LOG2_N  lower-wing write address

Behaviour:
- Clock i_clk. Reset i_rst is synchronous and active-high.
- Reset: state IDLE; s=0, b=0, drain counter=0; delay line cleared. All outputs are 0.
- States: IDLE, RUN, DRAIN, DONE. Transitions occur only on edges where i_en=1; i_rst overrides i_en.
- IDLE:
  - i_start=1 → RUN with s=0, b=0.
  - i_start is ignored in every other state. There is no queuing.
- RUN:
  - o_rd_en=1 with addresses computed from (s, b).
  - b increments each cycle.
  - At b=N/2-1: b wraps to 0 and the next state is DRAIN, with the drain counter loaded to BFLY_LAT.
- DRAIN:
  - o_rd_en=0 for BFLY_LAT cycles so the final writes of the stage land before the next stage reads.
  - At the end of DRAIN: if s=LOG2_N-1 → DONE, otherwise s increments → RUN.
- DONE:
  - o_done=1 for one cycle, then IDLE.
  - A start arriving during DONE is ignored.
- Outputs o_active and o_done decode from state only (Moore).
  - o_active=1 in RUN and DRAIN.
  - o_active rises the cycle after start is accepted, so it is high the first cycle the controller sits in its FFT state.
- Address arithmetic for stage s, butterfly b (all unsigned):
  - addr_a = ((b >> s) << (s+1)) | (b & (2^s-1))
  - addr_b = addr_a | (1 << s)
  - tw = (b & (2^s-1)) << (LOG2_N-1-s)
- Write path:
  - o_wr_en, o_wr_addr_a and o_wr_addr_b equal o_rd_en, o_rd_addr_a and o_rd_addr_b delayed by exactly BFLY_LAT enabled cycles, via a shift register that advances only when i_en=1.
- Timing with i_en held high:
  - Start accepted at edge 0.
  - o_active is high for LOG2_N*(N/2+BFLY_LAT) cycles.
  - o_done follows in the next cycle.
- i_en low mid-run: everything freezes, including the delay line. Outputs hold their values, and o_rd_en / o_wr_en keep their frozen values.
- Reset mid-operation: returns to the reset state in one edge, and pending delayed writes are discarded.

Optional Feature:
FFT_SEQ_ABORT_EN: adds input port i_abort (1 bit).
- With the macro: i_abort=1 with i_en=1 in RUN or DRAIN → IDLE on the next edge. The delay line is cleared, so no further o_wr_en occurs. No o_done pulse is issued, and o_active drops.
- Without the macro: the port is absent, and a transform always runs to completion.

Decomposition:
- Shared package fft_pkg:
  - state enum type t_fft_seq_state {IDLE, RUN, DRAIN, DONE};
  - function bfly_addr(s, b) returning {addr_a, addr_b, tw}, reused by the testbench reference model.
- One sub-module: fft_addr_delay, a parameterised BFLY_LAT-deep, enable-gated shift register carrying {rd_en, addr_a, addr_b}, with synchronous clear.

Test Plan:
- Reset: assert i_rst for 2 cycles → all outputs 0, state IDLE; i_start=0 held for 5 cycles → o_active stays 0.
- Full run, LOG2_N=3, BFLY_LAT=2, pulse i_start → o_active high for 18 cycles and o_done pulses on cycle 19. Read pairs/twiddles:
  - stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  Each write mirrors its read 2 cycles later.
- i_start held high during RUN and during DONE → ignored; exactly one o_done, then IDLE.
- i_en low for 3 cycles at stage 1, b=2 → outputs frozen, and the sequence resumes with identical addresses; total active cycles = 21.
- i_rst asserted in DRAIN of stage 1 → all outputs 0 next cycle, no stray o_wr_en; a fresh start then runs the full 18-cycle sequence.
- With FFT_SEQ_ABORT_EN, i_abort in RUN at stage 2, b=1 → IDLE next cycle, no o_done, no o_wr_en afterwards.
